// File: rtl/ps2_kbd_rx_if.sv
// Bus between the PS/2 receiver and its neighbours: raw keyboard lines in,
// received byte / decoded key / display mask out.
interface ps2_kbd_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] key_code;
    logic       key_valid;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;
    logic [7:0] disp_mask;

    // Receiver side: consumes the keyboard lines, drives the decoded results.
    modport master (
        input  ps2_clk, ps2_data,
        output rx_byte, rx_valid, key_code, key_valid,
        output is_break, is_ext, frame_err, disp_mask
    );

    // Keyboard / display side: drives the lines, consumes the results.
    modport slave (
        output ps2_clk, ps2_data,
        input  rx_byte, rx_valid, key_code, key_valid,
        input  is_break, is_ext, frame_err, disp_mask
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the raw lines, deframe
// 11-bit frames with odd parity, decode F0/E0 prefixes, drive display mask.
module ps2_kbd_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_kbd_rx_if.master  bus
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 0 = ps2_clk, index 1 = ps2_data
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] flt_cnt [2];
    logic          filt_clk_d;
    logic          strb;
    logic          dat;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          perr;
    logic [TW-1:0] tmo_cnt;
    logic          brk_pend;
    logic          ext_pend;

    // Two-stage synchroniser on both raw lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {bus.ps2_data, bus.ps2_clk};
            sync2 <= sync1;
        end
    end

    // Glitch filter: a line flips only after FILTER_LEN consecutive new-level samples
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt       <= 2'b11;
            filt_clk_d <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            filt_clk_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FW'(1);
                end
            end
        end
    end

    assign strb = filt_clk_d & ~filt[0];
    assign dat  = filt[1];

    // Frame FSM, timeout, prefix decode and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            perr          <= 1'b0;
            tmo_cnt       <= '0;
            brk_pend      <= 1'b0;
            ext_pend      <= 1'b0;
            bus.rx_byte   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.key_code  <= '0;
            bus.key_valid <= 1'b0;
            bus.is_break  <= 1'b0;
            bus.is_ext    <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.disp_mask <= '0;
        end else begin
            bus.rx_valid  <= 1'b0;
            bus.key_valid <= 1'b0;
            bus.frame_err <= 1'b0;

            if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYC)) begin
                // Stalled partial frame; takes priority over a coincident strobe
                state         <= IDLE;
                tmo_cnt       <= '0;
                bus.frame_err <= 1'b1;
                brk_pend      <= 1'b0;
                ext_pend      <= 1'b0;
            end else begin
                if (state == IDLE || strb) tmo_cnt <= '0;
                else                       tmo_cnt <= tmo_cnt + TW'(1);

                if (strb) begin
                    unique case (state)
                        IDLE: begin
                            if (!dat) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shreg   <= {dat, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= PARITY;
                        end
                        PARITY: begin
                            perr  <= ~(^{shreg, dat});
                            state <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (dat && !perr) begin
                                bus.rx_byte  <= shreg;
                                bus.rx_valid <= 1'b1;
                                if (shreg == 8'hF0) begin
                                    brk_pend <= 1'b1;
                                end else if (shreg == 8'hE0) begin
                                    ext_pend <= 1'b1;
                                end else begin
                                    bus.key_code  <= shreg;
                                    bus.is_break  <= brk_pend;
                                    bus.is_ext    <= ext_pend;
                                    bus.key_valid <= 1'b1;
                                    brk_pend      <= 1'b0;
                                    ext_pend      <= 1'b0;
                                    if (!brk_pend) bus.disp_mask <= 8'h03;
                                end
                            end else begin
                                bus.frame_err <= 1'b1;
                                brk_pend      <= 1'b0;
                                ext_pend      <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: tasks push expected bytes/keys/errors,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_ps2_kbd_rx;
    localparam int unsigned TMO = 2000;
    localparam int          H   = 40;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } key_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] exp_rx [$];
    key_t       exp_key [$];
    int         exp_err = 0;
    int         total   = 0;
    int         bad     = 0;
    int         cyc     = 0;
    int         err_cyc = 0;
    int         rx_seen = 0;
    logic       prev_rxv = 1'b0, prev_kv = 1'b0, prev_fe = 1'b0;
    logic [7:0] e_rx;
    key_t       e_key;
    key_t       g_key;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_seen++;
            total++;
            if (exp_rx.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected got=%h", bus.rx_byte);
            end else begin
                e_rx = exp_rx.pop_front();
                if (bus.rx_byte !== e_rx) begin
                    bad++;
                    $display("FAIL rx_byte got=%h exp=%h", bus.rx_byte, e_rx);
                end
            end
        end
        if (bus.key_valid) begin
            total++;
            g_key = {bus.key_code, bus.is_break, bus.is_ext};
            if (exp_key.size() == 0) begin
                bad++;
                $display("FAIL key_unexpected got=%h", g_key);
            end else begin
                e_key = exp_key.pop_front();
                if (g_key !== e_key || bus.rx_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL key_event got=%h/rxv=%b exp=%h/rxv=1", g_key, bus.rx_valid, e_key);
                end
            end
        end
        if (bus.frame_err) begin
            total++;
            err_cyc = cyc;
            if (exp_err == 0) begin
                bad++;
                $display("FAIL frame_err_unexpected got=1 exp=0");
            end else begin
                exp_err--;
            end
        end
        if ((bus.rx_valid && prev_rxv) || (bus.key_valid && prev_kv) || (bus.frame_err && prev_fe)) begin
            total++;
            bad++;
            $display("FAIL pulse_width got=multi-cycle exp=1 cycle");
        end
        prev_rxv = bus.rx_valid;
        prev_kv  = bus.key_valid;
        prev_fe  = bus.frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.ps2_data = b;
        tick(H);
        bus.ps2_clk = 1'b0;
        tick(H);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d) ^ bad_par);
        send_bit(1'b1);
        tick(H);
    endtask

    task automatic push_key(input logic [7:0] c, input logic brk, input logic ext);
        exp_key.push_back({c, brk, ext});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_rx.size() != 0 || exp_key.size() != 0 || exp_err != 0) && n < 300) begin
            tick(1);
            n++;
        end
        total++;
        if (exp_rx.size() != 0 || exp_key.size() != 0 || exp_err != 0) begin
            bad++;
            $display("FAIL %s_pending got rx=%0d key=%0d err=%0d exp=0/0/0",
                     name, exp_rx.size(), exp_key.size(), exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(4);
        total++;
        if ({bus.rx_byte, bus.rx_valid, bus.key_code, bus.key_valid, bus.is_break,
             bus.is_ext, bus.frame_err, bus.disp_mask} !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs got key=%h rx=%h mask=%h exp=all zero",
                     bus.key_code, bus.rx_byte, bus.disp_mask);
        end
        rst = 1'b1;
        tick(20);
    endtask

    task automatic test_good_frame();
        exp_rx.push_back(8'h1C);
        push_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain("good");
        total++;
        if (bus.disp_mask !== 8'h03 || bus.key_code !== 8'h1C) begin
            bad++;
            $display("FAIL good_state got mask=%h key=%h exp mask=03 key=1c", bus.disp_mask, bus.key_code);
        end
    endtask

    task automatic test_break();
        exp_rx.push_back(8'hF0);
        exp_rx.push_back(8'h1C);
        push_key(8'h1C, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain("break");
        total++;
        if (bus.is_break !== 1'b1 || bus.disp_mask !== 8'h03) begin
            bad++;
            $display("FAIL break_hold got brk=%b mask=%h exp brk=1 mask=03", bus.is_break, bus.disp_mask);
        end
    endtask

    task automatic test_ext_break();
        exp_rx.push_back(8'hE0);
        exp_rx.push_back(8'hF0);
        exp_rx.push_back(8'h75);
        push_key(8'h75, 1'b1, 1'b1);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        drain("ext_break");
        exp_rx.push_back(8'h32);
        push_key(8'h32, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0);
        drain("ext_plain");
    endtask

    task automatic test_parity_err();
        int rs;
        rs = rx_seen;
        exp_err++;
        send_frame(8'h1C, 1'b1);
        drain("parity");
        total++;
        if (bus.key_code !== 8'h32 || rx_seen !== rs) begin
            bad++;
            $display("FAIL parity_hold got key=%h rx_pulses=%0d exp key=32 rx_pulses=%0d",
                     bus.key_code, rx_seen, rs);
        end
        exp_rx.push_back(8'h32);
        push_key(8'h32, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0);
        drain("parity_recover");
    endtask

    task automatic test_timeout();
        int t_fall;
        int n;
        exp_err++;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        t_fall = cyc - H;
        n = 0;
        while (exp_err != 0 && n < int'(TMO) + 300) begin
            tick(1);
            n++;
        end
        total++;
        if (exp_err != 0) begin
            bad++;
            $display("FAIL timeout_missing got no frame_err exp frame_err");
        end
        total++;
        if (err_cyc - t_fall < int'(TMO) || err_cyc - t_fall > int'(TMO) + 40) begin
            bad++;
            $display("FAIL timeout_latency got=%0d exp=%0d..%0d", err_cyc - t_fall, TMO, TMO + 40);
        end
        exp_rx.push_back(8'h32);
        push_key(8'h32, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0);
        drain("timeout_recover");
        total++;
        if (bus.key_code !== 8'h32) begin
            bad++;
            $display("FAIL timeout_key got=%h exp=32", bus.key_code);
        end
    endtask

    task automatic test_glitch_reset();
        int rs;
        rs = rx_seen;
        bus.ps2_clk = 1'b0;
        tick(3);
        bus.ps2_clk = 1'b1;
        tick(60);
        total++;
        if (rx_seen !== rs) begin
            bad++;
            $display("FAIL glitch_rx got=%0d exp=%0d", rx_seen, rs);
        end
        exp_rx.push_back(8'h1C);
        push_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain("glitch_frame");
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        total++;
        if ({bus.rx_byte, bus.key_code, bus.is_break, bus.is_ext, bus.disp_mask} !== 26'd0) begin
            bad++;
            $display("FAIL midframe_reset got key=%h rx=%h mask=%h exp=all zero",
                     bus.key_code, bus.rx_byte, bus.disp_mask);
        end
        tick(100);
        exp_rx.push_back(8'h1C);
        push_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0);
        drain("after_reset");
        total++;
        if (bus.disp_mask !== 8'h03 || bus.key_code !== 8'h1C) begin
            bad++;
            $display("FAIL after_reset_state got mask=%h key=%h exp mask=03 key=1c",
                     bus.disp_mask, bus.key_code);
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_good_frame();
        test_break();
        test_ext_break();
        test_parity_err();
        test_timeout();
        test_glitch_reset();
        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
